// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, sequencer states, flag bit positions.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDR = 4'h2;
    localparam logic [3:0] OP_STR = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_AND = 4'h7;
    localparam logic [3:0] OP_OR  = 4'h8;
    localparam logic [3:0] OP_XOR = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_JZ  = 4'hD;
    localparam logic [3:0] OP_JC  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;

    // Instruction fields: opcode in the high nibble, operand field in the low nibble.
    function automatic logic [3:0] get_opcode(input logic [7:0] ir);
        return ir[7:4];
    endfunction

    function automatic logic [3:0] get_field(input logic [7:0] ir);
        return ir[3:0];
    endfunction

endpackage

// File: rtl/gp_regfile.sv
// General-purpose register file: one synchronous write port, one asynchronous read port.
module gp_regfile
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_N  = 16,
    localparam int unsigned IDX_W = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              CLB,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] regs_q [REG_N];

    // Register storage, cleared as a whole on reset.
    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/acc_cpu_core.sv
// Single-issue accumulator CPU: IDLE/FETCH/EXEC/HALT sequencer, inline ALU, Z/C flags.
module acc_cpu_core
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 8,
    parameter int unsigned REG_N  = 16
) (
    input  logic              clk,
    input  logic              CLB,
    output logic              inst_req,
    output logic [PC_W-1:0]   inst_addr,
    input  logic              inst_valid,
    input  logic [7:0]        inst_data,
    output logic [DATA_W-1:0] acc,
    output logic [PC_W-1:0]   pc,
    output logic              zflag,
    output logic              cflag,
    output logic              halted
);

    localparam int unsigned IDX_W = $clog2(REG_N);

    state_e            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [DATA_W-1:0] acc_q;
    logic [7:0]        ir_q;
    logic [1:0]        flags_q;
    logic              req_q;
    logic              halt_q;

    logic [3:0]        opcode;
    logic [3:0]        fld;
    logic [DATA_W-1:0] rdata;
    logic              rf_we;

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] acc_d;
    logic [1:0]        flags_d;
    logic [PC_W-1:0]   pc_d;

    assign opcode = get_opcode(ir_q);
    assign fld    = get_field(ir_q);
    assign rf_we  = (state_q == ST_EXEC) && (opcode == OP_STR);

    gp_regfile #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_regfile (
        .clk     (clk),
        .CLB     (CLB),
        .we_i    (rf_we),
        .waddr_i (fld[IDX_W-1:0]),
        .wdata_i (acc_q),
        .raddr_i (fld[IDX_W-1:0]),
        .rdata_o (rdata)
    );

    // ALU and branch target: results computed from the latched instruction, committed in EXEC.
    always_comb begin
        acc_d   = acc_q;
        flags_d = flags_q;
        pc_d    = pc_q;
        sum     = '0;
        case (opcode)
            OP_LDI: acc_d = DATA_W'(fld);
            OP_LDR: acc_d = rdata;
            OP_ADD: sum = {1'b0, acc_q} + {1'b0, rdata};
            OP_ADC: sum = {1'b0, acc_q} + {1'b0, rdata} + {{DATA_W{1'b0}}, flags_q[FLAG_C]};
            // C set means no borrow.
            OP_SUB: sum = {1'b0, acc_q} + {1'b0, ~rdata} + {{DATA_W{1'b0}}, 1'b1};
            OP_AND: begin
                acc_d           = acc_q & rdata;
                flags_d[FLAG_C] = 1'b0;
            end
            OP_OR: begin
                acc_d           = acc_q | rdata;
                flags_d[FLAG_C] = 1'b0;
            end
            OP_XOR: begin
                acc_d           = acc_q ^ rdata;
                flags_d[FLAG_C] = 1'b0;
            end
            OP_SHL: begin
                acc_d           = {acc_q[DATA_W-2:0], 1'b0};
                flags_d[FLAG_C] = acc_q[DATA_W-1];
            end
            OP_SHR: begin
                acc_d           = {1'b0, acc_q[DATA_W-1:1]};
                flags_d[FLAG_C] = acc_q[0];
            end
            OP_JMP: pc_d = PC_W'(rdata);
            // pc_q already points past the branch; the size cast sign-extends the offset.
            OP_JZ:  if (flags_q[FLAG_Z]) pc_d = pc_q + PC_W'($signed(fld));
            OP_JC:  if (flags_q[FLAG_C]) pc_d = pc_q + PC_W'($signed(fld));
            default: ;
        endcase
        if (opcode == OP_ADD || opcode == OP_ADC || opcode == OP_SUB) begin
            acc_d           = sum[DATA_W-1:0];
            flags_d[FLAG_C] = sum[DATA_W];
        end
        if (opcode >= OP_ADD && opcode <= OP_SHR) begin
            flags_d[FLAG_Z] = (acc_d == '0);
        end
    end

    // Sequencer with architectural state and registered handshake/halt outputs.
    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            acc_q   <= '0;
            ir_q    <= '0;
            flags_q <= '0;
            req_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_q <= ST_FETCH;
                    req_q   <= 1'b1;
                end
                ST_FETCH: begin
                    if (inst_valid) begin
                        ir_q    <= inst_data;
                        pc_q    <= pc_q + PC_W'(1);
                        req_q   <= 1'b0;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    acc_q   <= acc_d;
                    flags_q <= flags_d;
                    pc_q    <= pc_d;
                    if (opcode == OP_HLT) begin
                        state_q <= ST_HALT;
                        halt_q  <= 1'b1;
                    end else begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                ST_HALT: ;
            endcase
        end
    end

    assign inst_req  = req_q;
    assign inst_addr = pc_q;
    assign pc        = pc_q;
    assign acc       = acc_q;
    assign zflag     = flags_q[FLAG_Z];
    assign cflag     = flags_q[FLAG_C];
    assign halted    = halt_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Scoreboard bench for acc_cpu_core: the instruction driver pushes hand-computed results,
// a monitor pops them when an executed instruction retires.
module tb_acc_cpu_core;

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 8;
    localparam int unsigned RN = 16;

    logic          clk = 1'b0;
    logic          CLB;
    logic          inst_req;
    logic [PW-1:0] inst_addr;
    logic          inst_valid;
    logic [7:0]    inst_data;
    logic [DW-1:0] acc;
    logic [PW-1:0] pc;
    logic          zflag;
    logic          cflag;
    logic          halted;

    acc_cpu_core #(
        .DATA_W (DW),
        .PC_W   (PW),
        .REG_N  (RN)
    ) dut (
        .clk        (clk),
        .CLB        (CLB),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .acc        (acc),
        .pc         (pc),
        .zflag      (zflag),
        .cflag      (cflag),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]    ins;
        logic [DW-1:0] acc;
        logic [PW-1:0] pc;
        logic          z;
        logic          c;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          m_e;
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    logic          p1 = 1'b0;
    logic          p2 = 1'b0;
    logic [PW-1:0] exp_fetch = '0;
    logic [DW-1:0] last_acc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        if (CLB) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Retirement tracker: accept seen at edge k, result visible after edge k+1.
    always @(posedge clk or posedge CLB) begin
        if (CLB) begin
            p1 <= 1'b0;
            p2 <= 1'b0;
        end else begin
            p1 <= inst_req && inst_valid;
            p2 <= p1;
        end
    end

    always @(negedge clk) begin
        if (p2 && !CLB) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                m_e = sb_q.pop_front();
                chk($sformatf("acc[%02h]", m_e.ins), 32'(acc), 32'(m_e.acc));
                chk($sformatf("pc[%02h]", m_e.ins), 32'(pc), 32'(m_e.pc));
                chk($sformatf("z[%02h]", m_e.ins), 32'(zflag), 32'(m_e.z));
                chk($sformatf("c[%02h]", m_e.ins), 32'(cflag), 32'(m_e.c));
                chk($sformatf("halted[%02h]", m_e.ins), 32'(halted),
                    32'(m_e.ins[7:4] == 4'hF));
            end
        end
    end

    task automatic wait_req();
        int t = 0;
        @(negedge clk);
        while (!inst_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("fetch_req", 32'(inst_req), 32'd1);
    endtask

    // Present one instruction after 'waits' stalled FETCH cycles and queue its expected result.
    task automatic issue(input logic [7:0] ins, input int waits, input logic [DW-1:0] ea,
                         input logic [PW-1:0] ep, input logic ez, input logic ec);
        exp_t e;
        wait_req();
        chk("fetch_addr", 32'(inst_addr), 32'(exp_fetch));
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk("stall_req", 32'(inst_req), 32'd1);
            chk("stall_addr", 32'(inst_addr), 32'(exp_fetch));
            chk("stall_pc", 32'(pc), 32'(exp_fetch));
            chk("stall_acc", 32'(acc), 32'(last_acc));
        end
        inst_data  = ins;
        inst_valid = 1'b1;
        e = '{ins: ins, acc: ea, pc: ep, z: ez, c: ec};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        inst_data  = 8'h1F;
        exp_fetch  = ep;
        last_acc   = ea;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_acc"}, 32'(acc), 32'd0);
        chk({tag, "_pc"}, 32'(pc), 32'd0);
        chk({tag, "_addr"}, 32'(inst_addr), 32'd0);
        chk({tag, "_z"}, 32'(zflag), 32'd0);
        chk({tag, "_c"}, 32'(cflag), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_req"}, 32'(inst_req), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        CLB        = 1'b1;
        inst_valid = 1'b0;
        inst_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        CLB = 1'b0;

        // Zero-wait stream
        issue(8'h15, 0, 8'h05, 8'h01, 1'b0, 1'b0);
        issue(8'h33, 0, 8'h05, 8'h02, 1'b0, 1'b0);
        issue(8'h43, 0, 8'h0A, 8'h03, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("stream_cycles", 32'(cyc), 32'd7);

        // Carry chain
        issue(8'h1F, 0, 8'h0F, 8'h04, 1'b0, 1'b0);
        issue(8'hA0, 0, 8'h1E, 8'h05, 1'b0, 1'b0);
        issue(8'hA0, 0, 8'h3C, 8'h06, 1'b0, 1'b0);
        issue(8'hA0, 0, 8'h78, 8'h07, 1'b0, 1'b0);
        issue(8'hA0, 0, 8'hF0, 8'h08, 1'b0, 1'b0);
        issue(8'h30, 0, 8'hF0, 8'h09, 1'b0, 1'b0);
        issue(8'h40, 0, 8'hE0, 8'h0A, 1'b0, 1'b1);
        issue(8'h51, 0, 8'hE1, 8'h0B, 1'b0, 1'b0);

        // SUB and branches
        issue(8'h17, 0, 8'h07, 8'h0C, 1'b0, 1'b0);
        issue(8'h32, 0, 8'h07, 8'h0D, 1'b0, 1'b0);
        issue(8'h62, 0, 8'h00, 8'h0E, 1'b1, 1'b1);
        issue(8'hDE, 0, 8'h00, 8'h0D, 1'b1, 1'b1);
        issue(8'hE2, 0, 8'h00, 8'h10, 1'b1, 1'b1);
        issue(8'h80, 0, 8'hF0, 8'h11, 1'b0, 1'b0);
        issue(8'hD5, 0, 8'hF0, 8'h12, 1'b0, 1'b0);

        // Fetch stall, then logic/shift/load ops
        issue(8'h11, 5, 8'h01, 8'h13, 1'b0, 1'b0);
        issue(8'h91, 0, 8'h01, 8'h14, 1'b0, 1'b0);
        issue(8'hB0, 0, 8'h00, 8'h15, 1'b1, 1'b1);
        issue(8'h72, 0, 8'h00, 8'h16, 1'b1, 1'b0);
        issue(8'h23, 0, 8'h05, 8'h17, 1'b1, 1'b0);
        issue(8'h00, 0, 8'h05, 8'h18, 1'b1, 1'b0);

        // Halt: frozen while inst_valid pulses
        issue(8'hF0, 0, 8'h05, 8'h19, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            inst_valid = i[0];
            inst_data  = 8'h1F;
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_req", 32'(inst_req), 32'd0);
            chk("halt_pc", 32'(pc), 32'h19);
            chk("halt_acc", 32'(acc), 32'h05);
        end
        @(negedge clk);
        inst_valid = 1'b0;
        CLB        = 1'b1;
        #1;
        check_reset_outputs("halt_clr");
        @(negedge clk);
        CLB = 1'b0;
        chk("release_req", 32'(inst_req), 32'd0);
        @(negedge clk);
        chk("release_req_rise", 32'(inst_req), 32'd1);
        exp_fetch = '0;
        last_acc  = '0;

        // Registers cleared by reset; build 0xFF in R5 and wrap via JMP
        issue(8'h23, 0, 8'h00, 8'h01, 1'b0, 1'b0);
        issue(8'h1F, 0, 8'h0F, 8'h02, 1'b0, 1'b0);
        issue(8'h31, 0, 8'h0F, 8'h03, 1'b0, 1'b0);
        issue(8'hA0, 0, 8'h1E, 8'h04, 1'b0, 1'b0);
        issue(8'hA0, 0, 8'h3C, 8'h05, 1'b0, 1'b0);
        issue(8'hA0, 0, 8'h78, 8'h06, 1'b0, 1'b0);
        issue(8'hA0, 0, 8'hF0, 8'h07, 1'b0, 1'b0);
        issue(8'h81, 0, 8'hFF, 8'h08, 1'b0, 1'b0);
        issue(8'h35, 0, 8'hFF, 8'h09, 1'b0, 1'b0);
        issue(8'hC5, 0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        issue(8'h00, 0, 8'hFF, 8'h00, 1'b0, 1'b0);

        // Reset during a stalled fetch
        wait_req();
        repeat (2) @(negedge clk);
        CLB = 1'b1;
        #1;
        check_reset_outputs("midfetch");
        @(negedge clk);
        CLB       = 1'b0;
        exp_fetch = '0;
        last_acc  = '0;
        issue(8'h13, 0, 8'h03, 8'h01, 1'b0, 1'b0);
        issue(8'h25, 0, 8'h00, 8'h02, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acc_cpu_core.md
# acc_cpu_core

Parametrised successor to the 8-bit accumulator processor: a single-issue accumulator CPU with configurable data width, program-counter width and register count. It has a 4-state sequencer, an instruction-fetch request/valid handshake that tolerates wait states, a carry-chained ALU with persistent Z/C flags, relative conditional branches and a halt state. It sits between instruction memory and the board-level test harness, and replaces the fixed 8-bit controller/IR/PC/ACC/ALU/register-file assembly.

## Interface
- DATA_W, 8: accumulator, ALU and register width, ≥4
- PC_W, 8: program-counter and fetch-address width, ≥4
- REG_N, 16: general registers; power of two, 2..16
- clk  in  1  rising-edge clock
- CLB  in  1  asynchronous, active-high reset
- inst_req  out  1  fetch request
- inst_addr  out  PC_W  fetch address, equal to the current PC
- inst_valid  in  1  inst_data is valid; sampled only while inst_req=1
- inst_data  in  8  instruction: opcode[7:4], field f[3:0]
- acc  out  DATA_W  accumulator
- pc  out  PC_W  program counter
- zflag, cflag  out  1  Z and C flags
- halted  out  1  core is in HALT

## Operation
- States: IDLE, FETCH, EXEC, HALT. Transitions:
  - CLB: IDLE.
  - IDLE → FETCH.
  - FETCH → EXEC when inst_valid=1; otherwise stay in FETCH.
  - EXEC → FETCH, or → HALT on HLT.
  - HALT exits only on CLB.
- inst_req = (state==FETCH). On fetch accept: IR ← inst_data and pc ← pc+1, wrapping mod 2^PC_W.
- Register index = f mod REG_N. imm = f, zero-extended for LDI and sign-extended for branches.
- Opcodes:
  - 0 NOP.
  - 1 LDI: acc ← imm.
  - 2 LDR: acc ← R[f].
  - 3 STR: R[f] ← acc.
  - 4 ADD: acc ← acc+R.
  - 5 ADC: acc ← acc+R+C, using C from before this instruction.
  - 6 SUB: acc ← acc+~R+1.
  - 7 AND, 8 OR, 9 XOR with R.
  - A SHL: C ← acc[MSB], shift in 0.
  - B SHR: C ← acc[0], shift in 0.
  - C JMP: pc ← R[f][PC_W-1:0], zero-extended if DATA_W<PC_W.
  - D JZ: if Z then pc ← pc+sext(f).
  - E JC: if C then pc ← pc+sext(f).
  - F HLT.
- Flags:
  - Z ← (result==0) over DATA_W bits, for opcodes 4–B.
  - C ← carry out of bit DATA_W-1 for ADD/ADC/SUB. For SUB, C=1 means no borrow (acc ≥ R unsigned).
  - AND/OR/XOR clear C.
  - All other opcodes leave both flags unchanged.
- Branch offsets are relative to the already-incremented pc. Branch targets wrap mod 2^PC_W.

## Timing
- Reset values: pc=0, acc=0, all R=0, IR=0, zflag=0, cflag=0, halted=0, inst_req=0.
- The first inst_req rises one clk after CLB is released (IDLE cycle).
- An instruction takes 1+W FETCH cycles plus 1 EXEC cycle, where W is the number of wait cycles. Throughput with zero wait states is 2 cycles per instruction.
- acc, R, flags and branch-updated pc are visible on the edge that ends EXEC.
- inst_addr is held stable for the whole of FETCH. inst_valid is ignored outside FETCH.
- HALT: halted=1 from the edge ending EXEC of HLT. inst_req stays 0 and all state is frozen.
- Reset mid-fetch or mid-exec: all state clears immediately. An in-flight instruction is discarded with no register or flag write.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT)
  - state encoding (ST_IDLE, ST_FETCH, ST_EXEC, ST_HALT)
  - flag bit indices
- Sub-module gp_regfile (params DATA_W, REG_N): one synchronous write port, one asynchronous read port, cleared on CLB.
- The ALU is inline combinational logic in the core.

## Test plan
- Zero-wait stream 0x15, 0x33, 0x43 (DATA_W=8) → R3=0x05, acc=0x0A, Z=0, C=0, pc=0x03 after 6 cycles plus the IDLE cycle.
- Carry chain: load acc=0xF0 (LDI 0xF, SHL ×4), STR R0, ADD R0 → acc=0xE0, C=1. Then ADC R1 with R1=0 → acc=0xE1, C=0.
- SUB and branch: LDI 7, STR R2, SUB R2 → acc=0, Z=1, C=1. JZ 0xDE fetched at address a → pc=a+1−2.
- Fetch stall: inst_valid held low for 5 cycles → inst_req=1 and inst_addr constant throughout, acc/pc unchanged. Valid on cycle 6 → EXEC result visible on the next edge.
- HLT 0xF0 → halted=1 and inst_req=0, with inst_valid pulses ignored for 20 cycles. Then a CLB pulse → pc=0 and halted=0, and inst_req rises one cycle after release.
- Wrap and mid-op reset: R5=0xFF, JMP R5, NOP at 0xFF → pc=0x00. Assert CLB during a stalled FETCH → all outputs at reset values within the same cycle.
